sb_tx_clk_gen: RTL and testbench

//  Sideband TX clock generator/gater: emits TXCKSB as PKT_BITS gated PLL pulses per packet, then GAP_CYCLES idle.

---
 rtl/sb_clk_pkg.sv | 19 +
 rtl/sb_clk_icg.sv | 24 ++
 rtl/sb_tx_clk_gen.sv | 140 ++++++++++++++
 tb/tb_sb_tx_clk_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_clk_pkg.sv
// Shared types and defaults for the sideband TX clock generator.
package sb_clk_pkg;

  typedef enum logic [1:0] {
    SB_CLK_IDLE   = 2'd0,
    SB_CLK_ACTIVE = 2'd1,
    SB_CLK_GAP    = 2'd2
  } sb_clk_state_e;

  localparam int SB_PKT_BITS_DEF   = 64;
  localparam int SB_GAP_CYCLES_DEF = 32;
  localparam int SB_PEND_DEPTH_DEF = 2;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int sb_cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sb_clk_icg.sv
// Latch-based integrated clock gate. The enable is captured while the clock
// is low, so it can only change outside the high phase; the gated clock is
// therefore made only of full-width pulses. Reset forces the output low at once.
module sb_clk_icg (
  input  logic i_clk,
  input  logic i_en,
  input  logic i_rst,
  output logic o_gclk
);

  logic en_latch;

  // Enable latch: transparent while the clock is low, cleared by reset.
  always_latch begin
    if (i_rst) begin
      en_latch <= 1'b0;
    end else if (!i_clk) begin
      en_latch <= i_en;
    end
  end

  assign o_gclk = i_clk & en_latch & ~i_rst;

endmodule

// File: rtl/sb_tx_clk_gen.sv
// Sideband TX clock generator/gater. Each packet produces PKT_BITS gated PLL
// pulses on TXCKSB followed by GAP_CYCLES idle cycles. Packet-start requests
// are accepted with ready/valid and queued up to PEND_DEPTH deep.
// Optional feature: define SB_TX_CLK_PKT_CNT_EN to add the saturating
// o_pkt_cnt packet counter output.
module sb_tx_clk_gen
  import sb_clk_pkg::*;
#(
  parameter int PKT_BITS   = SB_PKT_BITS_DEF,
  parameter int GAP_CYCLES = SB_GAP_CYCLES_DEF,
  parameter int PEND_DEPTH = SB_PEND_DEPTH_DEF
) (
  input  logic                        i_pll_clk,
  input  logic                        i_rst,
  input  logic                        i_pkt_valid,
  output logic                        o_pkt_ready,
  output logic                        o_busy,
  output logic [$clog2(PKT_BITS)-1:0] o_bit_idx,
  output logic                        o_ser_done,
  output logic                        o_pack_finished,
`ifdef SB_TX_CLK_PKT_CNT_EN
  output logic [15:0]                 o_pkt_cnt,
`endif
  output logic                        TXCKSB
);

  localparam int BIT_W  = $clog2(PKT_BITS);
  localparam int GAP_W  = sb_cnt_w(GAP_CYCLES - 1);
  localparam int PEND_W = sb_cnt_w(PEND_DEPTH);

  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(PKT_BITS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_DEPTH);

  sb_clk_state_e     state_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [PEND_W-1:0] pend_cnt_reg;
  logic              ser_done_reg;
  logic              pack_fin_reg;

  logic accept;
  logic have_req;
  logic start_pkt;
  logic gate_en;

  // Ready depends only on queue occupancy, never on valid.
  assign o_pkt_ready = (pend_cnt_reg < PEND_MAX);
  assign accept      = i_pkt_valid & o_pkt_ready;
  // A request accepted this very cycle can start a packet without queueing.
  assign have_req    = (pend_cnt_reg != '0) | accept;
  assign start_pkt   = have_req &
                       ((state_reg == SB_CLK_IDLE) |
                        ((state_reg == SB_CLK_GAP) & (gap_cnt_reg == GAP_LAST)));

  // Pending-request queue depth: accept adds one, packet start removes one.
  always_ff @(posedge i_pll_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_cnt_reg <= '0;
    end else if (accept && !start_pkt) begin
      pend_cnt_reg <= pend_cnt_reg + 1'b1;
    end else if (!accept && start_pkt) begin
      pend_cnt_reg <= pend_cnt_reg - 1'b1;
    end
  end

  // Packet sequencer with registered serialize-done and gap flags.
  always_ff @(posedge i_pll_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= SB_CLK_IDLE;
      bit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      ser_done_reg <= 1'b0;
      pack_fin_reg <= 1'b0;
    end else begin
      ser_done_reg <= 1'b0;
      case (state_reg)
        SB_CLK_IDLE: begin
          bit_cnt_reg <= '0;
          if (start_pkt) begin
            state_reg <= SB_CLK_ACTIVE;
          end
        end
        SB_CLK_ACTIVE: begin
          if (bit_cnt_reg == BIT_LAST) begin
            state_reg    <= SB_CLK_GAP;
            gap_cnt_reg  <= '0;
            ser_done_reg <= 1'b1;
            pack_fin_reg <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        SB_CLK_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            pack_fin_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            state_reg    <= start_pkt ? SB_CLK_ACTIVE : SB_CLK_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= SB_CLK_IDLE;
          pack_fin_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = (state_reg != SB_CLK_IDLE) | (pend_cnt_reg != '0);
  assign o_bit_idx       = (state_reg == SB_CLK_ACTIVE) ? bit_cnt_reg : '0;
  assign o_ser_done      = ser_done_reg;
  assign o_pack_finished = pack_fin_reg;

`ifdef SB_TX_CLK_PKT_CNT_EN
  logic [15:0] pkt_cnt_reg;

  // Completed-packet counter, saturating at all ones.
  always_ff @(posedge i_pll_clk or posedge i_rst) begin
    if (i_rst) begin
      pkt_cnt_reg <= '0;
    end else if (ser_done_reg && (pkt_cnt_reg != 16'hFFFF)) begin
      pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
  end

  assign o_pkt_cnt = pkt_cnt_reg;
`endif

  assign gate_en = (state_reg == SB_CLK_ACTIVE);

  sb_clk_icg u_icg (
    .i_clk  (i_pll_clk),
    .i_en   (gate_en),
    .i_rst  (i_rst),
    .o_gclk (TXCKSB)
  );

endmodule

// File: tb/tb_sb_tx_clk_gen.sv
// Bench for sb_tx_clk_gen. The reference model tracks each packet as an offset
// from its start cycle (t): ACTIVE while t < PKT_BITS, GAP for the next
// GAP_CYCLES, plus a pending-request count. TXCKSB is sampled early in the high
// phase, late in the high phase and in the low phase of every cycle.
module tb_sb_tx_clk_gen;

  localparam int PB = 64;
  localparam int GB = 32;
  localparam int PD = 2;
  localparam int BW = $clog2(PB);

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_pkt_valid;
  logic          o_pkt_ready;
  logic          o_busy;
  logic [BW-1:0] o_bit_idx;
  logic          o_ser_done;
  logic          o_pack_finished;
  logic          TXCKSB;
`ifdef SB_TX_CLK_PKT_CNT_EN
  logic [15:0]   o_pkt_cnt;
`endif

  sb_tx_clk_gen #(.PKT_BITS(PB), .GAP_CYCLES(GB), .PEND_DEPTH(PD)) dut (
    .i_pll_clk       (clk),
    .i_rst           (i_rst),
    .i_pkt_valid     (i_pkt_valid),
    .o_pkt_ready     (o_pkt_ready),
    .o_busy          (o_busy),
    .o_bit_idx       (o_bit_idx),
    .o_ser_done      (o_ser_done),
    .o_pack_finished (o_pack_finished),
`ifdef SB_TX_CLK_PKT_CNT_EN
    .o_pkt_cnt       (o_pkt_cnt),
`endif
    .TXCKSB          (TXCKSB)
  );

  always #5 clk = ~clk;

  // Rising edges of the gated clock.
  int pulse_cnt = 0;
  always @(posedge TXCKSB) pulse_cnt <= pulse_cnt + 1;

  int vectors = 0;
  int fails   = 0;

  // Reference model state for the current cycle.
  int m_t     = -1;   // cycles since current packet start, -1 when none
  int m_pend  = 0;
  int m_gate  = 0;    // pulse expected in the current high phase
  int m_cnt   = 0;
  int m_acc   = 0;

  // One clock cycle: drive valid, check all outputs, advance the model.
  // Entered and left at posedge + 1.
  task automatic tick(input logic v);
    logic          e_ready, e_busy, e_sd, e_pf;
    logic [BW-1:0] e_idx;
    int            was_active;
    i_pkt_valid = v;
    #3;
    vectors++;
    if (TXCKSB !== m_gate[0]) begin
      fails++; $display("FAIL txcksb_high: got %b want %0d at %0t", TXCKSB, m_gate, $time);
    end
    @(negedge clk); #1;
    e_ready = (m_pend < PD);
    e_busy  = (m_t >= 0) || (m_pend > 0);
    e_idx   = (m_t >= 0 && m_t < PB) ? BW'(m_t) : '0;
    e_sd    = (m_t == PB);
    e_pf    = (m_t >= PB) && (m_t < PB + GB);
    vectors += 6;
    if (TXCKSB !== 1'b0) begin
      fails++; $display("FAIL txcksb_low: got %b want 0 at %0t", TXCKSB, $time);
    end
    if (o_pkt_ready !== e_ready) begin
      fails++; $display("FAIL ready: got %b want %b at %0t", o_pkt_ready, e_ready, $time);
    end
    if (o_busy !== e_busy) begin
      fails++; $display("FAIL busy: got %b want %b at %0t", o_busy, e_busy, $time);
    end
    if (o_bit_idx !== e_idx) begin
      fails++; $display("FAIL bit_idx: got %0d want %0d at %0t", o_bit_idx, e_idx, $time);
    end
    if (o_ser_done !== e_sd) begin
      fails++; $display("FAIL ser_done: got %b want %b at %0t", o_ser_done, e_sd, $time);
    end
    if (o_pack_finished !== e_pf) begin
      fails++; $display("FAIL pack_finished: got %b want %b at %0t", o_pack_finished, e_pf, $time);
    end
`ifdef SB_TX_CLK_PKT_CNT_EN
    vectors++;
    if (o_pkt_cnt !== 16'(m_cnt)) begin
      fails++; $display("FAIL pkt_cnt: got %0d want %0d at %0t", o_pkt_cnt, m_cnt, $time);
    end
`endif
    m_acc = (v && (m_pend < PD)) ? 1 : 0;
    @(posedge clk);
    was_active = (m_t >= 0 && m_t < PB) ? 1 : 0;
    if (m_t == PB && m_cnt < 16'hFFFF) m_cnt++;
    m_gate = was_active;
    if (m_t < 0 || m_t == PB + GB - 1) begin
      if (m_pend + m_acc > 0) begin
        m_t    = 0;
        m_pend = m_pend + m_acc - 1;
      end else begin
        m_t    = -1;
        m_pend = m_pend + m_acc;
      end
    end else begin
      m_t++;
      m_pend += m_acc;
    end
    #1;
    vectors++;
    if (TXCKSB !== m_gate[0]) begin
      fails++; $display("FAIL txcksb_rise: got %b want %0d at %0t", TXCKSB, m_gate, $time);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(m_t < 0 && m_pend == 0) && n < 1000) begin
      tick(1'b0);
      n++;
    end
    vectors++;
    if (!(m_t < 0 && m_pend == 0)) begin
      fails++; $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
    tick(1'b0);
  endtask

  task automatic model_reset();
    m_t = -1; m_pend = 0; m_gate = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    vectors += 5;
    if (TXCKSB !== 1'b0) begin fails++; $display("FAIL rst_txcksb: got %b want 0", TXCKSB); end
    if (o_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    if (o_bit_idx !== '0) begin fails++; $display("FAIL rst_bit_idx: got %0d want 0", o_bit_idx); end
    if (o_ser_done !== 1'b0) begin fails++; $display("FAIL rst_ser_done: got %b want 0", o_ser_done); end
    if (o_pack_finished !== 1'b0) begin fails++; $display("FAIL rst_pack_finished: got %b want 0", o_pack_finished); end
    @(negedge clk); #1;
    i_rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if (o_pkt_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", o_pkt_ready); end
    repeat (4) tick(1'b0);
    $display("test_reset done");
  endtask

  task automatic test_single();
    int p0 = pulse_cnt;
    tick(1'b1);
    drain();
    vectors++;
    if (pulse_cnt - p0 !== PB) begin
      fails++; $display("FAIL single_pulses: got %0d want %0d", pulse_cnt - p0, PB);
    end
    $display("test_single: %0d pulses", pulse_cnt - p0);
  endtask

  task automatic test_back_to_back();
    int p0 = pulse_cnt;
    int n_acc = 0;
    int n = 0;
    logic saw_not_ready = 1'b0;
    while (n_acc < 3 && n < 500) begin
      tick(1'b1);
      n_acc += m_acc;
      n++;
      if (o_pkt_ready === 1'b0) saw_not_ready = 1'b1;
    end
    drain();
    vectors += 2;
    if (saw_not_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_full: ready never dropped, got %b want 1", saw_not_ready);
    end
    if (pulse_cnt - p0 !== 3 * PB) begin
      fails++; $display("FAIL b2b_pulses: got %0d want %0d", pulse_cnt - p0, 3 * PB);
    end
    $display("test_back_to_back: %0d pulses", pulse_cnt - p0);
  endtask

  task automatic test_last_gap_accept();
    int p0 = pulse_cnt;
    int n = 0;
    tick(1'b1);
    while (m_t != PB + GB - 1 && n < 500) begin
      tick(1'b0);
      n++;
    end
    tick(1'b1);
    vectors++;
    if (o_bit_idx !== '0 || o_busy !== 1'b1) begin
      fails++; $display("FAIL lastgap_start: got busy=%b idx=%0d want busy=1 idx=0", o_busy, o_bit_idx);
    end
    drain();
    vectors++;
    if (pulse_cnt - p0 !== 2 * PB) begin
      fails++; $display("FAIL lastgap_pulses: got %0d want %0d", pulse_cnt - p0, 2 * PB);
    end
    $display("test_last_gap_accept: %0d pulses", pulse_cnt - p0);
  endtask

  task automatic test_random();
    int p0 = pulse_cnt;
    int mp0 = 0;
    int prob = 0;
    int probs[4] = '{2, 10, 50, 90};
    for (int i = 0; i < 1600; i++) begin
      if (i % 400 == 0) prob = probs[i / 400];
      if (m_gate != 0) mp0++;
      tick(($urandom_range(0, 99) < prob) ? 1'b1 : 1'b0);
    end
    drain();
    vectors++;
    if ((pulse_cnt - p0) % PB !== 0) begin
      fails++; $display("FAIL random_pulses: got %0d, not a multiple of %0d", pulse_cnt - p0, PB);
    end
    $display("test_random: %0d pulses", pulse_cnt - p0);
  endtask

  task automatic test_mid_reset();
    int p0;
    int n = 0;
    tick(1'b1);
    while (m_t != 30 && n < 200) begin
      tick(1'b0);
      n++;
    end
    i_rst = 1'b1;
    #1;
    vectors += 6;
    if (TXCKSB !== 1'b0) begin fails++; $display("FAIL mrst_txcksb: got %b want 0", TXCKSB); end
    if (o_busy !== 1'b0) begin fails++; $display("FAIL mrst_busy: got %b want 0", o_busy); end
    if (o_bit_idx !== '0) begin fails++; $display("FAIL mrst_bit_idx: got %0d want 0", o_bit_idx); end
    if (o_ser_done !== 1'b0) begin fails++; $display("FAIL mrst_ser_done: got %b want 0", o_ser_done); end
    if (o_pack_finished !== 1'b0) begin fails++; $display("FAIL mrst_pack_finished: got %b want 0", o_pack_finished); end
    if (o_pkt_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready: got %b want 1", o_pkt_ready); end
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (TXCKSB !== 1'b0) begin fails++; $display("FAIL mrst_hold: got %b want 0", TXCKSB); end
    end
    @(negedge clk); #1;
    i_rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    p0 = pulse_cnt;
    repeat (40) tick(1'b0);
    vectors++;
    if (pulse_cnt !== p0) begin
      fails++; $display("FAIL mrst_quiet: got %0d pulses want 0", pulse_cnt - p0);
    end
    p0 = pulse_cnt;
    tick(1'b1);
    drain();
    vectors++;
    if (pulse_cnt - p0 !== PB) begin
      fails++; $display("FAIL mrst_recover: got %0d want %0d", pulse_cnt - p0, PB);
    end
    $display("test_mid_reset: recovered with %0d pulses", pulse_cnt - p0);
  endtask

`ifdef SB_TX_CLK_PKT_CNT_EN
  task automatic test_pkt_cnt();
    repeat (5) begin
      tick(1'b1);
      drain();
    end
    vectors++;
    if (o_pkt_cnt !== 16'd5) begin
      fails++; $display("FAIL pktcnt_five: got %0d want 5", o_pkt_cnt);
    end
    force dut.pkt_cnt_reg = 16'hFFFE;
    @(posedge clk);
    release dut.pkt_cnt_reg;
    #1;
    m_cnt = 16'hFFFE;
    repeat (3) begin
      tick(1'b1);
      drain();
    end
    vectors++;
    if (o_pkt_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL pktcnt_sat: got %h want ffff", o_pkt_cnt);
    end
    $display("test_pkt_cnt: count %h", o_pkt_cnt);
  endtask
`endif

  initial begin
    i_rst       = 1'b1;
    i_pkt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
`ifdef SB_TX_CLK_PKT_CNT_EN
    test_pkt_cnt();
`endif
    test_single();
    test_back_to_back();
    test_last_gap_accept();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
